ps2_key_decoder: RTL and testbench



---
 rtl/ps2_pkg.sv | 29 ++
 rtl/ps2_rx.sv | 120 ++++++++++++
 rtl/ps2_key_decoder.sv | 224 ++++++++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard front end: decoder state encoding,
// scan-code and ASCII constants, and the frame parity helper.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BRK     = 2'd1,
    ST_EXT     = 2'd2,
    ST_EXT_BRK = 2'd3
  } dec_state_t;

  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_ENTER  = 8'h5A;

  localparam logic [7:0] ASCII_LF  = 8'h0A;
  localparam logic [7:0] ASCII_BS  = 8'h08;
  localparam logic [7:0] ASCII_ESC = 8'h1B;
  localparam logic [7:0] ASCII_SP  = 8'h20;

  // Data byte plus parity bit must contain an odd number of ones.
  function automatic logic odd_parity_ok(input logic [8:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: pin synchronizers, PS2_CLK glitch filter, frame shifter
// with start/parity/stop checks, and the idle timeout for partial frames.
import ps2_pkg::*;

module ps2_rx #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int TIMEOUT_US = 200,
  parameter int FILTER_LEN = 4
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] code,
  output logic       frame_done,
  output logic       frame_err
);

  localparam int TO_CYC = (CLK_HZ / 1_000_000) * TIMEOUT_US;
  localparam int TW     = $clog2(TO_CYC + 1);
  localparam int FW     = $clog2(FILTER_LEN + 1);
  localparam logic [TW-1:0] TO_LOAD   = TW'(TO_CYC);
  localparam logic [TW-1:0] TO_ONE    = TW'(1);
  localparam logic [TW-1:0] TO_ZERO   = TW'(0);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [FW-1:0] FILT_ONE  = FW'(1);

  logic [1:0]    clk_sync_r;
  logic [1:0]    data_sync_r;
  logic [FW-1:0] filt_cnt_r;
  logic          filt_r;
  logic          filt_prev_r;
  logic [3:0]    bit_cnt_r;
  logic [9:0]    shift_r;
  logic [TW-1:0] to_cnt_r;
  logic [7:0]    code_r;
  logic          done_r;
  logic          err_r;
  logic          fall_s;
  logic          frame_ok_s;
  logic          timeout_s;

  // Two-stage synchronizers; the bus idles high.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      clk_sync_r  <= 2'b11;
      data_sync_r <= 2'b11;
    end else begin
      clk_sync_r  <= {clk_sync_r[0], ps2_clk};
      data_sync_r <= {data_sync_r[0], ps2_data};
    end
  end

  // Filtered clock flips only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      filt_cnt_r  <= '0;
      filt_r      <= 1'b1;
      filt_prev_r <= 1'b1;
    end else begin
      filt_prev_r <= filt_r;
      if (clk_sync_r[1] == filt_r) begin
        filt_cnt_r <= '0;
      end else if (filt_cnt_r == FILT_LAST) begin
        filt_r     <= clk_sync_r[1];
        filt_cnt_r <= '0;
      end else begin
        filt_cnt_r <= filt_cnt_r + FILT_ONE;
      end
    end
  end

  assign fall_s = filt_prev_r & ~filt_r;
  // Stop bit is the live data sample; start sits at shift_r[0], parity at [9].
  assign frame_ok_s = ~shift_r[0] & data_sync_r[1] & odd_parity_ok(shift_r[9:1]);
  assign timeout_s  = (to_cnt_r == TO_ONE) & ~fall_s & (bit_cnt_r != 4'd0);

  // Frame shifter, end-of-frame checks and partial-frame timeout.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      bit_cnt_r <= 4'd0;
      shift_r   <= 10'd0;
      to_cnt_r  <= '0;
      code_r    <= 8'h00;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      if (fall_s) begin
        to_cnt_r <= TO_LOAD;
        if (bit_cnt_r == 4'd10) begin
          bit_cnt_r <= 4'd0;
          if (frame_ok_s) begin
            code_r <= shift_r[8:1];
            done_r <= 1'b1;
          end else begin
            err_r <= 1'b1;
          end
        end else begin
          shift_r   <= {data_sync_r[1], shift_r[9:1]};
          bit_cnt_r <= bit_cnt_r + 4'd1;
        end
      end else begin
        if (to_cnt_r != TO_ZERO) begin
          to_cnt_r <= to_cnt_r - TO_ONE;
        end
        if (timeout_s) begin
          bit_cnt_r <= 4'd0;
          err_r     <= 1'b1;
        end
      end
    end
  end

  assign code       = code_r;
  assign frame_done = done_r;
  assign frame_err  = err_r;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code to ASCII decoder: prefix FSM, shift/caps tracking and a
// one-deep valid/ready output register with sticky overrun.
import ps2_pkg::*;

module ps2_key_decoder #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int TIMEOUT_US = 200,
  parameter int FILTER_LEN = 4
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic [7:0] key_data,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       caps_lock,
  output logic       frame_err,
  output logic       overrun
);

  // Returns {hit, ascii} for a make code; letters honour shift ^ caps.
  function automatic logic [8:0] map_make(input logic [7:0] sc, input logic ext,
                                          input logic shift, input logic caps);
    logic [7:0] letter;
    logic [8:0] res;
    res    = 9'd0;
    letter = 8'h00;
    if (ext) begin
      if (sc == SC_ENTER) res = {1'b1, ASCII_LF};
      else                res = 9'd0;
    end else begin
      case (sc)
        8'h1C: letter = 8'h61;  8'h32: letter = 8'h62;  8'h21: letter = 8'h63;
        8'h23: letter = 8'h64;  8'h24: letter = 8'h65;  8'h2B: letter = 8'h66;
        8'h34: letter = 8'h67;  8'h33: letter = 8'h68;  8'h43: letter = 8'h69;
        8'h3B: letter = 8'h6A;  8'h42: letter = 8'h6B;  8'h4B: letter = 8'h6C;
        8'h3A: letter = 8'h6D;  8'h31: letter = 8'h6E;  8'h44: letter = 8'h6F;
        8'h4D: letter = 8'h70;  8'h15: letter = 8'h71;  8'h2D: letter = 8'h72;
        8'h1B: letter = 8'h73;  8'h2C: letter = 8'h74;  8'h3C: letter = 8'h75;
        8'h2A: letter = 8'h76;  8'h1D: letter = 8'h77;  8'h22: letter = 8'h78;
        8'h35: letter = 8'h79;  8'h1A: letter = 8'h7A;
        default: letter = 8'h00;
      endcase
      if (letter != 8'h00) begin
        res = {1'b1, (shift ^ caps) ? (letter - 8'h20) : letter};
      end else begin
        case (sc)
          8'h45:    res = {1'b1, shift ? 8'h29 : 8'h30};
          8'h16:    res = {1'b1, shift ? 8'h21 : 8'h31};
          8'h1E:    res = {1'b1, shift ? 8'h40 : 8'h32};
          8'h26:    res = {1'b1, shift ? 8'h23 : 8'h33};
          8'h25:    res = {1'b1, shift ? 8'h24 : 8'h34};
          8'h2E:    res = {1'b1, shift ? 8'h25 : 8'h35};
          8'h36:    res = {1'b1, shift ? 8'h5E : 8'h36};
          8'h3D:    res = {1'b1, shift ? 8'h26 : 8'h37};
          8'h3E:    res = {1'b1, shift ? 8'h2A : 8'h38};
          8'h46:    res = {1'b1, shift ? 8'h28 : 8'h39};
          8'h29:    res = {1'b1, ASCII_SP};
          SC_ENTER: res = {1'b1, ASCII_LF};
          8'h66:    res = {1'b1, ASCII_BS};
          8'h76:    res = {1'b1, ASCII_ESC};
          default:  res = 9'd0;
        endcase
      end
    end
    return res;
  endfunction

  logic [7:0] rx_code_s;
  logic       rx_done_s;
  logic       rx_err_s;
  dec_state_t state_r, state_nx_s;
  logic       lshift_r, lshift_nx_s;
  logic       rshift_r, rshift_nx_s;
  logic       caps_r, caps_nx_s;
  logic       caps_held_r, caps_held_nx_s;
  logic       mk_s, brk_s, ext_s;
  logic [8:0] map_s;
  logic       emit_s;
  logic [7:0] emit_data_s;
  logic       pend_valid_r;
  logic [7:0] pend_data_r;
  logic       key_valid_r;
  logic [7:0] key_data_r;
  logic       overrun_r;

  ps2_rx #(
    .CLK_HZ     (CLK_HZ),
    .TIMEOUT_US (TIMEOUT_US),
    .FILTER_LEN (FILTER_LEN)
  ) u_rx (
    .CLK        (CLK),
    .rst        (rst),
    .ps2_clk    (PS2_CLK),
    .ps2_data   (PS2_DATA),
    .code       (rx_code_s),
    .frame_done (rx_done_s),
    .frame_err  (rx_err_s)
  );

  assign map_s = map_make(rx_code_s, ext_s, lshift_r | rshift_r, caps_r);

  // Prefix FSM classifies each code, then modifiers and the ASCII map apply.
  always_comb begin
    state_nx_s     = state_r;
    lshift_nx_s    = lshift_r;
    rshift_nx_s    = rshift_r;
    caps_nx_s      = caps_r;
    caps_held_nx_s = caps_held_r;
    mk_s           = 1'b0;
    brk_s          = 1'b0;
    ext_s          = 1'b0;
    emit_s         = 1'b0;
    emit_data_s    = 8'h00;
    if (rx_done_s) begin
      case (state_r)
        ST_IDLE: begin
          if (rx_code_s == SC_BRK)      state_nx_s = ST_BRK;
          else if (rx_code_s == SC_EXT) state_nx_s = ST_EXT;
          else                          mk_s = 1'b1;
        end
        ST_BRK: begin
          brk_s      = 1'b1;
          state_nx_s = ST_IDLE;
        end
        ST_EXT: begin
          if (rx_code_s == SC_BRK) begin
            state_nx_s = ST_EXT_BRK;
          end else begin
            mk_s       = 1'b1;
            ext_s      = 1'b1;
            state_nx_s = ST_IDLE;
          end
        end
        ST_EXT_BRK: begin
          brk_s      = 1'b1;
          ext_s      = 1'b1;
          state_nx_s = ST_IDLE;
        end
        default: state_nx_s = ST_IDLE;
      endcase
    end else begin
      state_nx_s = state_r;
    end

    if (mk_s && !ext_s) begin
      case (rx_code_s)
        SC_LSHIFT: lshift_nx_s = 1'b1;
        SC_RSHIFT: rshift_nx_s = 1'b1;
        SC_CAPS: begin
          // Typematic repeats of caps lock must not re-toggle.
          if (!caps_held_r) caps_nx_s = ~caps_r;
          else              caps_nx_s = caps_r;
          caps_held_nx_s = 1'b1;
        end
        default: begin
          emit_s      = map_s[8];
          emit_data_s = map_s[7:0];
        end
      endcase
    end else if (mk_s) begin
      emit_s      = map_s[8];
      emit_data_s = map_s[7:0];
    end else if (brk_s && !ext_s) begin
      case (rx_code_s)
        SC_LSHIFT: lshift_nx_s    = 1'b0;
        SC_RSHIFT: rshift_nx_s    = 1'b0;
        SC_CAPS:   caps_held_nx_s = 1'b0;
        default:   caps_held_nx_s = caps_held_r;
      endcase
    end else begin
      emit_s = 1'b0;
    end
  end

  // Decoder state, modifier flags and the one-cycle decoded-byte stage.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      lshift_r     <= 1'b0;
      rshift_r     <= 1'b0;
      caps_r       <= 1'b0;
      caps_held_r  <= 1'b0;
      pend_valid_r <= 1'b0;
      pend_data_r  <= 8'h00;
    end else begin
      state_r      <= state_nx_s;
      lshift_r     <= lshift_nx_s;
      rshift_r     <= rshift_nx_s;
      caps_r       <= caps_nx_s;
      caps_held_r  <= caps_held_nx_s;
      pend_valid_r <= emit_s;
      if (emit_s) pend_data_r <= emit_data_s;
    end
  end

  // Output register: load when empty or being drained, else drop and flag.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      key_valid_r <= 1'b0;
      key_data_r  <= 8'h00;
      overrun_r   <= 1'b0;
    end else begin
      if (pend_valid_r) begin
        if (!key_valid_r || key_ready) begin
          key_valid_r <= 1'b1;
          key_data_r  <= pend_data_r;
        end else begin
          overrun_r <= 1'b1;
        end
      end else if (key_valid_r && key_ready) begin
        key_valid_r <= 1'b0;
      end
    end
  end

  assign key_data  = key_data_r;
  assign key_valid = key_valid_r;
  assign caps_lock = caps_r;
  assign frame_err = rx_err_s;
  assign overrun   = overrun_r;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: a table of scan-code sequences with
// expected ASCII output, plus hand sequences for errors, timeout, overrun and reset.
module tb_ps2_key_decoder;

  logic       CLK;
  logic       rst;
  logic       PS2_CLK;
  logic       PS2_DATA;
  logic [7:0] key_data;
  logic       key_valid;
  logic       key_ready;
  logic       caps_lock;
  logic       frame_err;
  logic       overrun;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int stop_cyc = 0;
  int rise_cyc = 0;
  int ferr_cnt = 0;
  logic kv_prev = 1'b0;
  logic [7:0] got_q[$];

  typedef struct {
    string           name;
    logic [7:0][7:0] codes;
    int              ncodes;
    logic [4:0][7:0] exp;
    int              nexp;
    logic            caps;
  } vec_t;

  vec_t vec[9];

  ps2_key_decoder #(
    .CLK_HZ     (1_000_000),
    .TIMEOUT_US (200),
    .FILTER_LEN (4)
  ) dut (
    .CLK       (CLK),
    .rst       (rst),
    .PS2_CLK   (PS2_CLK),
    .PS2_DATA  (PS2_DATA),
    .key_data  (key_data),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .caps_lock (caps_lock),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (key_valid && key_ready) got_q.push_back(key_data);
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
    if (key_valid && !kv_prev) rise_cyc <= cyc;
    kv_prev <= key_valid;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sends the first nbits of a frame; the keyboard drives data while its clock is high.
  task automatic send_frame(input logic [7:0] sc, input int nbits, input bit bad_par);
    logic [10:0] fr;
    logic        par;
    par = bad_par ? (^sc) : ~(^sc);
    fr  = {1'b1, par, sc, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      PS2_DATA = fr[i];
      tick(8);
      PS2_CLK = 1'b0;
      if (i == 10) stop_cyc = cyc;
      tick(15);
      PS2_CLK = 1'b1;
      tick(7);
    end
    PS2_DATA = 1'b1;
    tick(20);
  endtask

  function automatic logic [31:0] got_at(input int k);
    if (k < got_q.size()) return {24'h0, got_q[k]};
    else                  return 32'hDEAD;
  endfunction

  initial begin
    int d;
    int f0;
    vec[0] = '{"make_break",  64'h1C_F0_1C,                3, 40'h61,             1, 1'b0};
    vec[1] = '{"shift_l",     64'h12_1C_F0_1C_F0_12_1C,    7, 40'h41_61,          2, 1'b0};
    vec[2] = '{"shift_r",     64'h59_16_F0_16_F0_59,       6, 40'h21,             1, 1'b0};
    vec[3] = '{"caps_on",     64'h58_F0_58_32,             4, 40'h42,             1, 1'b1};
    vec[4] = '{"caps_shift",  64'h12_32_F0_32_F0_12,       6, 40'h62,             1, 1'b1};
    vec[5] = '{"caps_repeat", 64'h58_58_F0_58,             4, 40'h00,             0, 1'b0};
    vec[6] = '{"specials",    64'h45_29_5A_66_76,          5, 40'h30_20_0A_08_1B, 5, 1'b0};
    vec[7] = '{"extended",    64'hE0_5A_E0_F0_5A_E0_75_07, 8, 40'h0A,             1, 1'b0};
    vec[8] = '{"shift_digit", 64'h12_45_F0_45_F0_12,       6, 40'h29,             1, 1'b0};

    rst = 1'b0; PS2_CLK = 1'b1; PS2_DATA = 1'b1; key_ready = 1'b1;
    tick(5);
    check("reset key_valid", {31'h0, key_valid}, 32'h0);
    check("reset key_data",  {24'h0, key_data},  32'h0);
    check("reset caps_lock", {31'h0, caps_lock}, 32'h0);
    check("reset frame_err", {31'h0, frame_err}, 32'h0);
    check("reset overrun",   {31'h0, overrun},   32'h0);
    rst = 1'b1;
    tick(5);

    // Decode latency from the stop-bit clock edge to key_valid.
    got_q.delete();
    send_frame(8'h1C, 11, 1'b0);
    d = rise_cyc - stop_cyc;
    check("latency window", {31'h0, (d >= 7 && d <= 11)}, 32'h1);
    check("latency byte", got_at(0), 32'h61);
    send_frame(8'hF0, 11, 1'b0);
    send_frame(8'h1C, 11, 1'b0);
    check("break silent", got_q.size(), 32'd1);

    for (int v = 0; v < 9; v++) begin
      got_q.delete();
      for (int k = 0; k < vec[v].ncodes; k++) send_frame(vec[v].codes[vec[v].ncodes-1-k], 11, 1'b0);
      tick(20);
      check({vec[v].name, " count"}, got_q.size(), vec[v].nexp);
      for (int k = 0; k < vec[v].nexp; k++)
        check($sformatf("%s byte%0d", vec[v].name, k), got_at(k), {24'h0, vec[v].exp[vec[v].nexp-1-k]});
      check({vec[v].name, " caps"}, {31'h0, caps_lock}, {31'h0, vec[v].caps});
    end
    check("no frame_err in vectors", ferr_cnt, 32'd0);
    check("no overrun in vectors", {31'h0, overrun}, 32'h0);

    // Bad parity drops the frame with a single error pulse.
    f0 = ferr_cnt;
    got_q.delete();
    send_frame(8'h43, 11, 1'b1);
    check("parity err pulses", ferr_cnt - f0, 32'd1);
    check("parity no output", got_q.size(), 32'd0);
    send_frame(8'h5A, 11, 1'b0);
    check("after parity byte", got_at(0), 32'h0A);
    check("after parity err pulses", ferr_cnt - f0, 32'd1);

    // Partial frame abandoned past the timeout.
    f0 = ferr_cnt;
    got_q.delete();
    send_frame(8'h4B, 5, 1'b0);
    check("timeout not early", ferr_cnt - f0, 32'd0);
    tick(300);
    check("timeout err pulse", ferr_cnt - f0, 32'd1);
    send_frame(8'h4B, 11, 1'b0);
    check("after timeout byte", got_at(0), 32'h6C);
    check("after timeout count", got_q.size(), 32'd1);

    // Back-pressure: second byte dropped, held byte intact.
    key_ready = 1'b0;
    got_q.delete();
    send_frame(8'h1C, 11, 1'b0);
    send_frame(8'h32, 11, 1'b0);
    tick(5);
    check("hold key_valid", {31'h0, key_valid}, 32'h1);
    check("hold key_data",  {24'h0, key_data},  32'h61);
    check("overrun set",    {31'h0, overrun},   32'h1);
    key_ready = 1'b1;
    tick(3);
    check("drain count", got_q.size(), 32'd1);
    check("drain byte", got_at(0), 32'h61);
    check("drain key_valid low", {31'h0, key_valid}, 32'h0);
    check("overrun sticky", {31'h0, overrun}, 32'h1);

    // Reset mid-frame with caps set and overrun sticky.
    send_frame(8'h58, 11, 1'b0);
    check("caps before reset", {31'h0, caps_lock}, 32'h1);
    send_frame(8'h1C, 6, 1'b0);
    rst = 1'b0;
    #2;
    check("async reset key_data", {24'h0, key_data},  32'h0);
    check("async reset overrun",  {31'h0, overrun},   32'h0);
    check("async reset caps",     {31'h0, caps_lock}, 32'h0);
    check("async reset valid",    {31'h0, key_valid}, 32'h0);
    tick(3);
    rst = 1'b1;
    tick(3);
    got_q.delete();
    send_frame(8'h1C, 11, 1'b0);
    check("post reset byte", got_at(0), 32'h61);
    check("post reset count", got_q.size(), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
